// File: rtl/dds_sweep_ctrl.sv
// Register-configured linear frequency sweep sequencer feeding the DDS core strobes.
// Optional triangle (up/down) sweep is built when DDS_SWEEP_UPDOWN_EN is defined.
//
// state   | meaning
// IDLE    | outputs low, waiting for start
// LOAD_P  | phase-load strobe, cur_f primed with F_START
// LOAD_F  | frequency-load strobe with cur_f, dwell timer armed
// DWELL   | dwell timer counts down to zero
// STEP    | pick next tuning word, wrap, turn around or finish
// DONE    | sweep finished, DDS left running on last word
module dds_sweep_ctrl #(
    parameter int W       = 16,
    parameter int DWELL_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [15:0]  cfg_data,
    input  logic         start,
    input  logic         abort,
    output logic         Enable,
    output logic         LoadP,
    output logic         LoadF,
    output logic [W-1:0] FreqPhase,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_P, S_LOAD_F, S_DWELL, S_STEP, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [W-1:0]        f_start, f_stop, f_step, phase;
    logic [DWELL_W-1:0]  dwell, dwell_cnt, dwell_nxt;
    logic [W-1:0]        cur_f, cur_f_nxt;
    logic                mode_rep, updown;
    logic                dir, dir_nxt;
    logic [W:0]          sum_up, diff_dn;
    logic                up_ok, dn_ok;
    logic                cfg_open;

    assign cfg_open = (state == S_IDLE) || (state == S_DONE);

`ifdef DDS_SWEEP_UPDOWN_EN
    logic mode_ud;
    assign updown = mode_ud;
`else
    assign updown = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            f_start  <= '0;
            f_stop   <= '0;
            f_step   <= '0;
            dwell    <= '0;
            phase    <= '0;
            mode_rep <= 1'b0;
`ifdef DDS_SWEEP_UPDOWN_EN
            mode_ud  <= 1'b0;
`endif
        end else if (cfg_we && cfg_open) begin
            case (cfg_addr)
                3'd0: f_start <= W'(cfg_data);
                3'd1: f_stop  <= W'(cfg_data);
                3'd2: f_step  <= W'(cfg_data);
                3'd3: dwell   <= DWELL_W'(cfg_data);
                3'd4: phase   <= W'(cfg_data);
                3'd5: begin
                    mode_rep <= cfg_data[0];
`ifdef DDS_SWEEP_UPDOWN_EN
                    mode_ud  <= cfg_data[1];
`endif
                end
                default: ;
            endcase
        end
    end

    // One extra bit so a wrap past 2^W (or below 0) is seen as out of range.
    assign sum_up  = {1'b0, cur_f} + {1'b0, f_step};
    assign diff_dn = {1'b0, cur_f} - {1'b0, f_step};
    assign up_ok   = !sum_up[W] && (sum_up[W-1:0] <= f_stop);
    assign dn_ok   = !diff_dn[W] && (diff_dn[W-1:0] >= f_start);

    always_comb begin
        state_nxt = state;
        cur_f_nxt = cur_f;
        dwell_nxt = dwell_cnt;
        dir_nxt   = dir;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD_P;
            S_LOAD_P: begin
                cur_f_nxt = f_start;
                dir_nxt   = 1'b0;
                state_nxt = S_LOAD_F;
            end
            S_LOAD_F: begin
                dwell_nxt = dwell;
                state_nxt = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_cnt == '0) state_nxt = S_STEP;
                else                 dwell_nxt = dwell_cnt - DWELL_W'(1);
            end
            S_STEP: begin
                state_nxt = S_LOAD_F;
                if (!updown || !dir) begin
                    if (up_ok) begin
                        cur_f_nxt = sum_up[W-1:0];
                    end else if (updown && dn_ok) begin
                        dir_nxt   = 1'b1;
                        cur_f_nxt = diff_dn[W-1:0];
                    end else if (mode_rep) begin
                        cur_f_nxt = updown ? cur_f : f_start;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    if (dn_ok) begin
                        cur_f_nxt = diff_dn[W-1:0];
                    end else if (mode_rep) begin
                        dir_nxt   = 1'b0;
                        cur_f_nxt = up_ok ? sum_up[W-1:0] : cur_f;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:   if (start) state_nxt = S_LOAD_P;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Outputs are decoded from the next state so the strobes line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_f     <= '0;
            dwell_cnt <= '0;
            dir       <= 1'b0;
            Enable    <= 1'b0;
            LoadP     <= 1'b0;
            LoadF     <= 1'b0;
            FreqPhase <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_f     <= cur_f_nxt;
            dwell_cnt <= dwell_nxt;
            dir       <= dir_nxt;
            Enable    <= (state_nxt != S_IDLE);
            LoadP     <= (state_nxt == S_LOAD_P);
            LoadF     <= (state_nxt == S_LOAD_F);
            FreqPhase <= (state_nxt == S_LOAD_P) ? phase :
                         (state_nxt == S_LOAD_F) ? cur_f_nxt : '0;
            busy      <= (state_nxt == S_LOAD_P) || (state_nxt == S_LOAD_F) ||
                         (state_nxt == S_DWELL)  || (state_nxt == S_STEP);
            done      <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: table of sweep configs with expected load sequences,
// scoreboarded against the strobes, plus hand sequences for abort/reset/restart.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, abort;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        Enable, LoadP, LoadF, busy, done;
    logic [15:0] FreqPhase;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.W(16), .DWELL_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .abort(abort), .Enable(Enable), .LoadP(LoadP), .LoadF(LoadF),
        .FreqPhase(FreqPhase), .busy(busy), .done(done)
    );

    typedef struct {
        int          rel;
        logic        p;
        logic [15:0] val;
    } ev_t;

    typedef struct {
        logic [15:0]       fs, fe, st, dw, ph;
        logic [1:0]        mode;
        int                run;
        int                done_at;
        int                n;
        logic [7:0][15:0]  v;
    } scn_t;

    ev_t  sb[$];
    ev_t  e;
    scn_t tbl[8];

    int checks = 0, failures = 0;
    int cyc = 0, t0 = 0, cur_done_at = -1, rel = 0;
    bit mon_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s rel=%0d got=%0h want=%0h", nm, cyc - t0, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            rel = cyc - t0;
            check("enable", Enable, 1);
            check("done", done, (cur_done_at >= 0 && rel >= cur_done_at));
            if (LoadP || LoadF) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_load rel=%0d got_p=%0b got_val=%0h want=none",
                             rel, LoadP, FreqPhase);
                end else begin
                    e = sb.pop_front();
                    check("load_cycle", rel, e.rel);
                    check("load_kind", LoadP, e.p);
                    check("load_value", FreqPhase, e.val);
                end
            end else begin
                check("freqphase_idle", FreqPhase, 0);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        nxt();
        cfg_we = 1'b0;
    endtask

    task automatic cfg(input logic [15:0] fs, input logic [15:0] fe, input logic [15:0] st,
                       input logic [15:0] dw, input logic [15:0] ph, input logic [1:0] m);
        wr(3'd0, fs); wr(3'd1, fe); wr(3'd2, st); wr(3'd3, dw); wr(3'd4, ph);
        wr(3'd5, {14'd0, m});
        wr(3'd6, 16'hFFFF); wr(3'd7, 16'hFFFF);
    endtask

    task automatic push(input int r, input logic p, input logic [15:0] v);
        ev_t x;
        x.rel = r; x.p = p; x.val = v;
        sb.push_back(x);
    endtask

    task automatic kick(input logic [15:0] ph, input int dn);
        t0 = cyc;
        cur_done_at = dn;
        push(1, 1'b1, ph);
        mon_en = 1'b1;
        start = 1'b1;
        nxt();
        start = 1'b0;
    endtask

    task automatic stop_chk();
        abort = 1'b1;
        mon_en = 1'b0;
        nxt();
        check("abort_enable", Enable, 0);
        check("abort_loadf", LoadF, 0);
        check("abort_busy", busy, 0);
        check("abort_fp", FreqPhase, 0);
        abort = 1'b0;
        check("missing_loads", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_scn(input int i);
        cfg(tbl[i].fs, tbl[i].fe, tbl[i].st, tbl[i].dw, tbl[i].ph, tbl[i].mode);
        kick(tbl[i].ph, tbl[i].done_at);
        for (int k = 0; k < tbl[i].n; k++)
            push(2 + k * (int'(tbl[i].dw) + 3), 1'b0, tbl[i].v[k]);
        repeat (tbl[i].run - 1) nxt();
        check("final_done", done, tbl[i].done_at >= 0);
        check("final_busy", busy, tbl[i].done_at < 0);
        check("final_enable", Enable, 1);
        stop_chk();
    endtask

    initial begin
        tbl[0] = '{fs:16'd100, fe:16'd130, st:16'd10, dw:16'd2, ph:16'h4000, mode:2'd0,
                   run:26, done_at:22, n:4,
                   v:{16'd0, 16'd0, 16'd0, 16'd0, 16'd130, 16'd120, 16'd110, 16'd100}};
        tbl[1] = '{fs:16'd100, fe:16'd130, st:16'd10, dw:16'd2, ph:16'h4000, mode:2'd1,
                   run:29, done_at:-1, n:6,
                   v:{16'd0, 16'd0, 16'd110, 16'd100, 16'd130, 16'd120, 16'd110, 16'd100}};
        tbl[2] = '{fs:16'hFFF0, fe:16'hFFFF, st:16'h0020, dw:16'd2, ph:16'h0000, mode:2'd0,
                   run:10, done_at:7, n:1,
                   v:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFF0}};
        tbl[3] = '{fs:16'd100, fe:16'd130, st:16'd0, dw:16'd1, ph:16'h1234, mode:2'd0,
                   run:19, done_at:-1, n:5,
                   v:{16'd0, 16'd0, 16'd0, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100}};
        tbl[4] = '{fs:16'd200, fe:16'd100, st:16'd10, dw:16'd0, ph:16'h0000, mode:2'd0,
                   run:8, done_at:5, n:1,
                   v:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd200}};
        tbl[5] = '{fs:16'd200, fe:16'd100, st:16'd10, dw:16'd0, ph:16'h0000, mode:2'd1,
                   run:10, done_at:-1, n:3,
                   v:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd200, 16'd200, 16'd200}};
`ifdef DDS_SWEEP_UPDOWN_EN
        tbl[6] = '{fs:16'd100, fe:16'd130, st:16'd10, dw:16'd2, ph:16'h4000, mode:2'd3,
                   run:39, done_at:-1, n:8,
                   v:{16'd110, 16'd100, 16'd110, 16'd120, 16'd130, 16'd120, 16'd110, 16'd100}};
        tbl[7] = '{fs:16'd100, fe:16'd130, st:16'd10, dw:16'd2, ph:16'h4000, mode:2'd2,
                   run:40, done_at:37, n:7,
                   v:{16'd0, 16'd100, 16'd110, 16'd120, 16'd130, 16'd120, 16'd110, 16'd100}};
`else
        tbl[6] = '{fs:16'd100, fe:16'd130, st:16'd10, dw:16'd2, ph:16'h4000, mode:2'd3,
                   run:39, done_at:-1, n:8,
                   v:{16'd130, 16'd120, 16'd110, 16'd100, 16'd130, 16'd120, 16'd110, 16'd100}};
        tbl[7] = '{fs:16'd100, fe:16'd130, st:16'd10, dw:16'd2, ph:16'h4000, mode:2'd2,
                   run:26, done_at:22, n:4,
                   v:{16'd0, 16'd0, 16'd0, 16'd0, 16'd130, 16'd120, 16'd110, 16'd100}};
`endif

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; abort = 1'b0;
        repeat (3) nxt();
        check("rst_enable", Enable, 0);
        check("rst_loadp", LoadP, 0);
        check("rst_loadf", LoadF, 0);
        check("rst_fp", FreqPhase, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        nxt();

        for (int i = 0; i < 8; i++) run_scn(i);

        // Start while busy and a config write while busy are both ignored; abort mid-dwell.
        cfg(16'd100, 16'd130, 16'd10, 16'd2, 16'h4000, 2'd0);
        kick(16'h4000, -1);
        push(2, 1'b0, 16'd100);
        nxt(); nxt();
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'd500;
        nxt();
        start = 1'b0; cfg_we = 1'b0;
        stop_chk();
        kick(16'h4000, -1);
        push(2, 1'b0, 16'd100);
        nxt(); nxt();
        stop_chk();

        // Simultaneous start and abort from IDLE stays in IDLE.
        start = 1'b1; abort = 1'b1;
        nxt();
        start = 1'b0; abort = 1'b0;
        check("sa_enable", Enable, 0);
        check("sa_loadp", LoadP, 0);
        check("sa_busy", busy, 0);
        nxt();
        check("sa_enable2", Enable, 0);
        check("sa_loadf2", LoadF, 0);

        // Restart from DONE.
        kick(16'h4000, 22);
        push(2, 1'b0, 16'd100); push(7, 1'b0, 16'd110);
        push(12, 1'b0, 16'd120); push(17, 1'b0, 16'd130);
        repeat (23) nxt();
        check("done_hold", done, 1);
        kick(16'h4000, -1);
        push(2, 1'b0, 16'd100);
        nxt(); nxt();
        stop_chk();

        // Reset mid-sweep clears outputs and configuration.
        kick(16'h4000, -1);
        push(2, 1'b0, 16'd100); push(7, 1'b0, 16'd110);
        repeat (7) nxt();
        rst = 1'b1;
        mon_en = 1'b0;
        nxt();
        check("mrst_enable", Enable, 0);
        check("mrst_loadp", LoadP, 0);
        check("mrst_loadf", LoadF, 0);
        check("mrst_fp", FreqPhase, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        rst = 1'b0;
        check("mrst_missing_loads", sb.size(), 0);
        sb.delete();
        nxt();
        kick(16'h0000, -1);
        push(2, 1'b0, 16'd0);
        push(5, 1'b0, 16'd0);
        repeat (5) nxt();
        stop_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
